// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register: clearable ctrl, sticky data, rd index, 2-entry skid buffer, hazard compare.
// Latency 1 cycle EMPTY->out_valid; in_ready is registered (low only when both entries are held).
module pipe_stage_skid #(
    parameter int                 CTRL_W      = 32,
    parameter int                 DATA_W      = 64,
    parameter int                 RD_W        = 5,
    parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = {CTRL_W{1'b0}},
    parameter int                 RFWE_BIT    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [RD_W-1:0]   out_rd,
    output logic [1:0]        occupancy,
    input  logic [RD_W-1:0]   hz_rs_a,
    input  logic [RD_W-1:0]   hz_rs_b,
    output logic              hz_hit_a,
    output logic              hz_hit_b
);

    typedef struct packed {
        logic              vld;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
        logic [RD_W-1:0]   rd;
    } entry_t;

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   in_ready_q, in_ready_d;
    logic   push, pop;
    entry_t in_ent;

    assign push   = in_valid & in_ready_q;
    assign pop    = main_q.vld & out_ready;
    assign in_ent = '{vld: 1'b1, ctrl: in_ctrl, data: in_data, rd: in_rd};

    // Occupancy is the state: skid is only ever valid while main is valid.
    always_comb begin
        main_d = main_q;
        skid_d = skid_q;
        if (flush) begin
            main_d.vld  = 1'b0;
            main_d.ctrl = BUBBLE_CTRL;
            main_d.rd   = '0;
            skid_d.vld  = 1'b0;
            skid_d.ctrl = BUBBLE_CTRL;
            skid_d.rd   = '0;
        end else begin
            case ({skid_q.vld, main_q.vld})
                2'b00: begin
                    if (push) main_d = in_ent;
                end
                2'b01: begin
                    if (push && pop)  main_d = in_ent;
                    else if (push)    skid_d = in_ent;
                    else if (pop)     main_d.vld = 1'b0;
                end
                2'b11: begin
                    if (pop) begin
                        main_d      = skid_q;
                        skid_d.vld  = 1'b0;
                        skid_d.ctrl = BUBBLE_CTRL;
                        skid_d.rd   = '0;
                    end
                end
                default: ;
            endcase
        end
        in_ready_d = ~(main_d.vld & skid_d.vld);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_q     <= '{vld: 1'b0, ctrl: BUBBLE_CTRL, data: '0, rd: '0};
            skid_q     <= '{vld: 1'b0, ctrl: BUBBLE_CTRL, data: '0, rd: '0};
            in_ready_q <= 1'b1;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    function automatic logic writes_reg(input entry_t e, input logic [RD_W-1:0] rs);
        return e.vld & e.ctrl[RFWE_BIT] & (e.rd != '0) & (e.rd == rs);
    endfunction

    assign in_ready  = in_ready_q;
    assign out_valid = main_q.vld;
    assign out_ctrl  = main_q.vld ? main_q.ctrl : BUBBLE_CTRL;
    assign out_rd    = main_q.vld ? main_q.rd : '0;
    assign out_data  = main_q.data;
    assign occupancy = {1'b0, main_q.vld} + {1'b0, skid_q.vld};
    assign hz_hit_a  = writes_reg(main_q, hz_rs_a) | writes_reg(skid_q, hz_rs_a);
    assign hz_hit_b  = writes_reg(main_q, hz_rs_b) | writes_reg(skid_q, hz_rs_b);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed steps then random traffic against a queue-based model.
module tb_pipe_stage_skid;
    localparam int CTRL_W = 32;
    localparam int DATA_W = 64;
    localparam int RD_W   = 5;
    localparam logic [CTRL_W-1:0] BUBBLE = '0;

    logic              clk = 1'b0;
    logic              reset, flush, in_valid, out_ready;
    logic              in_ready, out_valid, hz_hit_a, hz_hit_b;
    logic [CTRL_W-1:0] in_ctrl, out_ctrl;
    logic [DATA_W-1:0] in_data, out_data;
    logic [RD_W-1:0]   in_rd, out_rd, hz_rs_a, hz_rs_b;
    logic [1:0]        occupancy;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .CTRL_W(CTRL_W), .DATA_W(DATA_W), .RD_W(RD_W), .BUBBLE_CTRL(BUBBLE), .RFWE_BIT(0)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data), .out_rd(out_rd),
        .occupancy(occupancy),
        .hz_rs_a(hz_rs_a), .hz_rs_b(hz_rs_b),
        .hz_hit_a(hz_hit_a), .hz_hit_b(hz_hit_b)
    );

    typedef struct {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
        logic [RD_W-1:0]   rd;
    } ent_t;

    ent_t              q[$];
    logic [DATA_W-1:0] head_data;
    int                checks = 0;
    int                failures = 0;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: a FIFO of at most two entries; data output remembers the last head seen.
    task automatic model_edge();
        int   n;
        logic push, pop;
        ent_t e;
        n    = q.size();
        push = in_valid && (n < 2);
        pop  = (n > 0) && out_ready;
        if (reset) begin
            q.delete();
            head_data = '0;
        end else if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                e.ctrl = in_ctrl; e.data = in_data; e.rd = in_rd;
                q.push_back(e);
            end
            if (q.size() > 0) head_data = q[0].data;
        end
    endtask

    function automatic logic model_hit(input logic [RD_W-1:0] rs);
        logic h;
        h = 1'b0;
        foreach (q[i])
            if (q[i].ctrl[0] && q[i].rd != 0 && q[i].rd == rs) h = 1'b1;
        return h;
    endfunction

    task automatic check_all();
        logic v;
        v = (q.size() > 0);
        chk("out_valid", 64'(out_valid), 64'(v));
        chk("out_ctrl",  64'(out_ctrl),  v ? 64'(q[0].ctrl) : 64'(BUBBLE));
        chk("out_rd",    64'(out_rd),    v ? 64'(q[0].rd) : 64'd0);
        chk("out_data",  out_data,       head_data);
        chk("occupancy", 64'(occupancy), 64'(q.size()));
        chk("in_ready",  64'(in_ready),  64'(q.size() < 2));
        chk("hz_hit_a",  64'(hz_hit_a),  64'(model_hit(hz_rs_a)));
        chk("hz_hit_b",  64'(hz_hit_b),  64'(model_hit(hz_rs_b)));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [RD_W-1:0] r);
        in_valid = v;
        in_ctrl  = c;
        in_rd    = r;
        in_data  = {$urandom, $urandom};
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        hz_rs_a = '0; hz_rs_b = '0;
        drive(1'b0, '0, '0);
        head_data = '0;
        cyc(); cyc();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_data", out_data, 64'd0);
        reset = 1'b0;

        // Streaming
        out_ready = 1'b1;
        drive(1'b1, 32'h11, 5'd1); cyc(); chk("stream0", 64'(out_ctrl), 64'h11);
        drive(1'b1, 32'h22, 5'd2); cyc(); chk("stream1", 64'(out_ctrl), 64'h22);
        drive(1'b1, 32'h33, 5'd3); cyc(); chk("stream2", 64'(out_ctrl), 64'h33);
        chk("stream_occ", 64'(occupancy), 64'd1);
        drive(1'b0, '0, '0); cyc();
        chk("stream_drain", 64'(out_valid), 64'd0);

        // Backpressure
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 5'd3); cyc();
        drive(1'b1, 32'hB, 5'd4); cyc();
        chk("bp_occ", 64'(occupancy), 64'd2);
        chk("bp_rdy", 64'(in_ready), 64'd0);
        chk("bp_head", 64'(out_ctrl), 64'hA);
        drive(1'b1, 32'hE, 5'd9); cyc();
        out_ready = 1'b1; drive(1'b0, '0, '0); cyc();
        chk("bp_second", 64'(out_rd), 64'd4);
        chk("bp_rdy_back", 64'(in_ready), 64'd1);
        cyc();
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Flush with a coincident push
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 5'd3); cyc();
        drive(1'b1, 32'hB, 5'd4); cyc();
        flush = 1'b1; drive(1'b1, 32'hC, 5'd5); cyc();
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_ctrl", 64'(out_ctrl), 64'(BUBBLE));
        chk("fl_occ", 64'(occupancy), 64'd0);
        flush = 1'b0; out_ready = 1'b1; drive(1'b0, '0, '0); cyc();
        chk("fl_no_c", 64'(out_valid), 64'd0);

        // Hazard compare
        out_ready = 1'b0; hz_rs_a = 5'd7; hz_rs_b = 5'd0;
        drive(1'b1, 32'h1, 5'd7); cyc();
        drive(1'b1, 32'h1, 5'd0); cyc();
        chk("hz_a_hit", 64'(hz_hit_a), 64'd1);
        chk("hz_b_r0", 64'(hz_hit_b), 64'd0);
        flush = 1'b1; drive(1'b0, '0, '0); cyc(); flush = 1'b0;
        drive(1'b1, 32'h0, 5'd7); cyc();
        drive(1'b1, 32'h1, 5'd0); cyc();
        chk("hz_a_nowe", 64'(hz_hit_a), 64'd0);
        flush = 1'b1; drive(1'b0, '0, '0); cyc(); flush = 1'b0;

        // Reset beats flush
        drive(1'b1, 32'h5, 5'd6); cyc();
        chk("rp_occ1", 64'(occupancy), 64'd1);
        reset = 1'b1; flush = 1'b1; drive(1'b1, 32'h6, 5'd2); cyc();
        chk("rp_valid", 64'(out_valid), 64'd0);
        chk("rp_data", out_data, 64'd0);
        chk("rp_rdy", 64'(in_ready), 64'd1);
        reset = 1'b0; flush = 1'b0;

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_ctrl   = $urandom;
            in_data   = {$urandom, $urandom};
            in_rd     = RD_W'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            reset     = ($urandom_range(0, 499) == 0);
            hz_rs_a   = RD_W'($urandom_range(0, 7));
            hz_rs_b   = RD_W'($urandom_range(0, 7));
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
